// File: rtl/uart_pkg.sv
// Shared UART receive definitions: framing characters, default rates, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DEF_CLK_FREQ  = 100_000_000;
  localparam int DEF_BAUD_RATE = 57_600;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Payload bytes are everything except the blank and line-ending characters.
  function automatic logic is_payload(input logic [7:0] b);
    return !((b == CHAR_SPACE) || (b == CHAR_CR) || (b == CHAR_LF));
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous serial line into the clk domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running, idles high out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Reset to the line idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver with byte classification, payload counter and CR/LF line detect.
// Latency: rx_valid/frame_err one cycle after the synchronized stop-bit midpoint sample.
// Backpressure: none; serial input cannot be stalled, every pulse is single-cycle.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       clr_count,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [7:0] data_count,
  output logic       line_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             stop_ok, stop_bad;
  logic             cr_pending;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // FSM state, baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: half-bit qualify the start bit, then sample every full bit at its midpoint.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = RX_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            stop_ok = 1'b1;
            state_d = RX_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A break holds the line low; wait it out so it cannot start a new frame.
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // Registered outputs, byte classification and saturating payload counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      line_done  <= 1'b0;
      data_count <= 8'h00;
      cr_pending <= 1'b0;
    end else begin
      rx_valid  <= stop_ok;
      frame_err <= stop_bad;
      line_done <= stop_ok && cr_pending && (shift_q == CHAR_LF);
      if (stop_ok) rx_byte <= shift_q;
      if (stop_ok)       cr_pending <= (shift_q == CHAR_CR);
      else if (stop_bad) cr_pending <= 1'b0;
      if (clr_count)
        data_count <= 8'h00;
      else if (stop_ok && is_payload(shift_q) && (data_count != 8'hFF))
        data_count <= data_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at a reduced clock rate (16 clocks per bit).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_ctrl;
  import uart_pkg::*;

  // 921600 / 57600 = 16 clocks per bit keeps the 256-byte run short.
  localparam int TB_CLK_FREQ = 921_600;
  localparam int TB_BAUD     = 57_600;
  localparam int C           = TB_CLK_FREQ / TB_BAUD;
  localparam int HALF        = C / 2;
  // Edges from driving the start bit to rx_valid: 2 sync + 1 IDLE + half bit + 9 bits.
  localparam int LAT         = 9 * C + HALF + 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       clr_count;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic [7:0] data_count;
  logic       line_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t_start  = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_ld     = 0;
  int n_ld_ok  = 0;
  int n_both   = 0;
  int last_lat = 0;
  int v0, f0;

  uart_rx_ctrl #(.CLK_FREQ(TB_CLK_FREQ), .BAUD_RATE(TB_BAUD)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .clr_count  (clr_count),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .data_count (data_count),
    .line_done  (line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid  <= n_valid + 1;
      last_lat <= cyc - t_start;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (line_done) begin
      n_ld <= n_ld + 1;
      if (rx_valid && rx_byte == CHAR_LF) n_ld_ok <= n_ld_ok + 1;
    end
    if (rx_valid && frame_err) n_both <= n_both + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rx = 1'b0; t_start = cyc;
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (C) @(posedge clk);
    #1 rx = stop_bit;
    repeat (C) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 clr_count = 1'b1;
    @(posedge clk); #1 clr_count = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] pb;
    reset = 1'b1; rx = 1'b1; clr_count = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_byte", 32'(rx_byte), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_ld", 32'(line_done), 32'h0);
    chk("rst_count", 32'(data_count), 32'h00);
    chk("rst_state", 32'(dut.state_q), 32'(RX_IDLE));
    @(posedge clk); #1 reset = 1'b0;

    // Single byte 0x41 with exact pulse timing.
    send_frame(8'h41, 1'b1); settle();
    chk("a_nvalid", 32'(n_valid), 32'd1);
    chk("a_byte", 32'(rx_byte), 32'h41);
    chk("a_count", 32'(data_count), 32'd1);
    chk("a_ferr", 32'(n_ferr), 32'd0);
    chk("a_lat", 32'(last_lat), 32'(LAT));

    // "A", space, "B": space is not payload.
    pulse_clr();
    chk("clr_count", 32'(data_count), 32'd0);
    send_frame(8'h41, 1'b1); send_frame(8'h20, 1'b1); send_frame(8'h42, 1'b1); settle();
    chk("asb_nvalid", 32'(n_valid), 32'd4);
    chk("asb_count", 32'(data_count), 32'd2);
    chk("asb_byte", 32'(rx_byte), 32'h42);
    chk("asb_ld", 32'(n_ld), 32'd0);

    // CR LF -> one line_done, coincident with the LF rx_valid; lone LF and CR x LF -> none.
    pulse_clr();
    send_frame(8'h0D, 1'b1); send_frame(8'h0A, 1'b1); settle();
    chk("crlf_ld", 32'(n_ld), 32'd1);
    chk("crlf_coinc", 32'(n_ld_ok), 32'd1);
    chk("crlf_count", 32'(data_count), 32'd0);
    send_frame(8'h0A, 1'b1); settle();
    chk("lf_alone_ld", 32'(n_ld), 32'd1);
    send_frame(8'h0D, 1'b1); send_frame(8'h58, 1'b1); send_frame(8'h0A, 1'b1); settle();
    chk("cr_x_lf_ld", 32'(n_ld), 32'd1);
    chk("cr_x_lf_count", 32'(data_count), 32'd1);
    chk("cr_x_lf_byte", 32'(rx_byte), 32'h0A);

    // Short low glitch, under half a bit: rejected in START.
    v0 = n_valid; f0 = n_ferr;
    @(posedge clk); #1 rx = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    @(negedge clk);
    chk("glitch_valid", 32'(n_valid), 32'(v0));
    chk("glitch_ferr", 32'(n_ferr), 32'(f0));
    chk("glitch_state", 32'(dut.state_q), 32'(RX_IDLE));

    // 0x55 with a bad stop bit and a 5-bit break, then 0x31.
    pulse_clr();
    v0 = n_valid;
    send_frame(8'h55, 1'b0);
    repeat (5 * C) @(posedge clk);
    #1 rx = 1'b1;
    repeat (2 * C) @(posedge clk);
    @(negedge clk);
    chk("ferr_count", 32'(n_ferr), 32'd1);
    chk("ferr_novalid", 32'(n_valid), 32'(v0));
    chk("ferr_byte_held", 32'(rx_byte), 32'h0A);
    chk("ferr_state", 32'(dut.state_q), 32'(RX_IDLE));
    send_frame(8'h31, 1'b1); settle();
    chk("after_ferr_byte", 32'(rx_byte), 32'h31);
    chk("after_ferr_count", 32'(data_count), 32'd1);
    chk("after_ferr_nvalid", 32'(n_valid), 32'(v0 + 1));
    chk("never_both", 32'(n_both), 32'd0);

    // clr_count on the same edge as the increment: clear wins.
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (LAT) @(posedge clk);
        #1 clr_count = 1'b1;
        @(posedge clk); #1 clr_count = 1'b0;
      end
    join
    settle();
    chk("clr_vs_inc_byte", 32'(rx_byte), 32'h33);
    chk("clr_vs_inc_count", 32'(data_count), 32'd0);

    // Reset during data bit 4 of 0xA5: abort, no pulse, then 0x7E received.
    v0 = n_valid; f0 = n_ferr;
    pb = 8'hA5;
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 5; i++) begin
      repeat (C) @(posedge clk);
      #1 rx = pb[i];
    end
    repeat (HALF) @(posedge clk);
    @(negedge clk);
    chk("mid_state", 32'(dut.state_q), 32'(RX_DATA));
    chk("mid_idx", 32'(dut.idx_q), 32'd4);
    @(posedge clk); #1 reset = 1'b1; rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mrst_byte", 32'(rx_byte), 32'h00);
    chk("mrst_count", 32'(data_count), 32'h00);
    chk("mrst_state", 32'(dut.state_q), 32'(RX_IDLE));
    @(posedge clk); #1 reset = 1'b0;
    repeat (2 * C) @(posedge clk);
    @(negedge clk);
    chk("mrst_nopulse", 32'(n_valid + n_ferr), 32'(v0 + f0));
    send_frame(8'h7E, 1'b1); settle();
    chk("mrst_7e_byte", 32'(rx_byte), 32'h7E);
    chk("mrst_7e_count", 32'(data_count), 32'd1);

    // 256 payload bytes saturate the counter at 255; clr_count returns it to 0.
    for (int i = 0; i < 256; i++) send_frame(8'h61, 1'b1);
    settle();
    chk("sat_count", 32'(data_count), 32'd255);
    pulse_clr();
    @(negedge clk);
    chk("sat_clr", 32'(data_count), 32'd0);
    chk("final_both", 32'(n_both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
